activation_deskew: RTL and testbench

- Sits directly downstream of the 32-lane activation memory bank.
- That bank emits activations on 32 lanes of 16 bits, staggered by one cycle per lane: lane last_row starts first and lane 0 starts last.
- This block buffers each lane, realigns the beats into whole 512-bit vectors, and hands them out on a valid/ready stream to the result-write path.
- Lanes above last_row are inactive; their positions in each output vector are zero.

---
 rtl/activation_deskew_pkg.sv | 20 ++
 rtl/activation_deskew_if.sv | 25 ++
 rtl/deskew_lane_buf.sv | 57 +++++
 rtl/activation_deskew.sv | 139 +++++++++++++
 tb/tb_activation_deskew.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/activation_deskew_pkg.sv
// Shared constants and types for the activation deskew block.
// Lane counts use one extra bit so that a full lane and an empty lane can be told apart.
package activation_deskew_pkg;

    localparam int unsigned LANES = 32;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    typedef logic [DW-1:0] lane_t;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } deskew_state_e;

endpackage

// File: rtl/activation_deskew_if.sv
// Aligned-vector output stream of the deskew block.
// Uses valid/ready flow control with an end-of-batch marker.
interface activation_deskew_if;
    import activation_deskew_pkg::*;

    logic [LANES*DW-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/deskew_lane_buf.sv
// Per-lane beat buffer: private write pointer, shared read pointer from the top level.
// Occupancy is the pointer difference, so a read and a write in one cycle cancel out.
module deskew_lane_buf
    import activation_deskew_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr_i,
    input  logic  wr_en_i,
    input  lane_t wr_data_i,
    input  cnt_t  rd_ptr_i,
    output lane_t rd_data_o,
    output logic  non_empty_o,
    output logic  full_o,
    output logic  ovf_o
);

    lane_t mem_q [DEPTH];
    cnt_t  wr_ptr_q, wr_ptr_d;
    cnt_t  cnt;
    ptr_t  wr_idx, rd_idx;
    logic  wr_fire;

    assign cnt         = wr_ptr_q - rd_ptr_i;
    assign full_o      = (cnt == cnt_t'(DEPTH));
    assign non_empty_o = (cnt != '0);
    // Fullness is judged before any same-cycle read, so such a beat is still dropped.
    assign wr_fire     = wr_en_i && !full_o;
    assign ovf_o       = wr_en_i && full_o;
    assign wr_idx      = wr_ptr_q[AW-1:0];
    assign rd_idx      = rd_ptr_i[AW-1:0];
    assign rd_data_o   = mem_q[rd_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
        end else if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/activation_deskew.sv
// Realigns the one-cycle-per-lane staggered activation stream into whole vectors.
// Holds the FSM, the shared read pointer, the vector countdown and the output register.
module activation_deskew
    import activation_deskew_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [4:0]             last_row_i,
    input  logic [5:0]             batch_i,
    input  logic [LANES*DW-1:0]    activation_in_i,
    input  logic [LANES-1:0]       activation_in_valid_i,
    activation_deskew_if.master    out_if,
    output logic                   busy_o,
    output logic                   err_overflow_o
);

    deskew_state_e       state_q, state_d;
    logic [4:0]          act_rows_q, act_rows_d;
    logic [6:0]          remaining_q, remaining_d;
    cnt_t                rd_ptr_q, rd_ptr_d;
    logic [LANES*DW-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                err_q, err_d;

    logic [LANES-1:0] lane_active, lane_non_empty, lane_full, lane_ovf, lane_wr_en;
    lane_t            lane_rd_data [LANES];
    logic             start_fire, vec_ready, load, final_accept;

    assign start_fire = (state_q == IDLE) && start_i;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_active[g] = (act_rows_q >= 5'(g));
        assign lane_wr_en[g]  = (state_q == RUN) && activation_in_valid_i[g] && lane_active[g];

        deskew_lane_buf u_buf (
            .clk         (clk),
            .reset       (reset),
            .clr_i       (start_fire),
            .wr_en_i     (lane_wr_en[g]),
            .wr_data_i   (activation_in_i[g*DW +: DW]),
            .rd_ptr_i    (rd_ptr_q),
            .rd_data_o   (lane_rd_data[g]),
            .non_empty_o (lane_non_empty[g]),
            .full_o      (lane_full[g]),
            .ovf_o       (lane_ovf[g])
        );
    end

    // Inactive lanes never gate readiness.
    assign vec_ready    = &(lane_non_empty | ~lane_active);
    assign load         = (state_q == RUN) && (remaining_q != '0) && vec_ready &&
                          (!out_valid_q || out_if.out_ready);
    assign final_accept = (state_q == FLUSH) && out_valid_q && out_if.out_ready && out_last_q;

    always_comb begin
        state_d     = state_q;
        act_rows_d  = act_rows_q;
        remaining_d = remaining_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = RUN;
                    act_rows_d  = last_row_i;
                    remaining_d = 7'(batch_i) + 7'd1;
                    rd_ptr_d    = '0;
                    err_d       = 1'b0;
                end
            end
            RUN: begin
                if (load && (remaining_q == 7'd1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (final_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (|lane_ovf) begin
            err_d = 1'b1;
        end

        if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (load) begin
            for (int i = 0; i < LANES; i++) begin
                out_data_d[i*DW +: DW] = lane_active[i] ? lane_rd_data[i] : '0;
            end
            out_valid_d = 1'b1;
            out_last_d  = (remaining_q == 7'd1);
            rd_ptr_d    = rd_ptr_q + cnt_t'(1);
            remaining_d = remaining_q - 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            act_rows_q  <= '0;
            remaining_q <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_rows_q  <= act_rows_d;
            remaining_q <= remaining_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    // Drops in the accepting cycle of the final vector, not one cycle later.
    assign busy_o           = (state_q != IDLE) && !final_accept;
    assign err_overflow_o   = err_q;

endmodule

// File: tb/tb_activation_deskew.sv
// Self-checking bench: per-lane beat queues form the reference; vector k is the k-th
// stored beat of every active lane, zeros elsewhere, last on vector batch.
module tb_activation_deskew;
    import activation_deskew_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [4:0]          last_row;
    logic [5:0]          batch;
    logic [LANES*DW-1:0] act_in;
    logic [LANES-1:0]    act_valid;
    logic                busy;
    logic                err;

    activation_deskew_if u_if ();

    activation_deskew u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .start_i               (start),
        .last_row_i            (last_row),
        .batch_i               (batch),
        .activation_in_i       (act_in),
        .activation_in_valid_i (act_valid),
        .out_if                (u_if),
        .busy_o                (busy),
        .err_overflow_o        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    lane_t               beats [LANES][$];
    int                  m_lr, m_batch, head;
    logic [LANES*DW-1:0] got_vecs [64];
    logic                stalled = 1'b0;
    logic [LANES*DW-1:0] stall_data;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else if (u_if.out_valid) begin
            if (head > m_batch) begin
                chk("extra_vector", u_if.out_valid, 1'b0);
            end else begin
                logic [LANES*DW-1:0] exp;
                exp = '0;
                for (int i = 0; i <= m_lr; i++) begin
                    if (beats[i].size() > head) exp[i*DW +: DW] = beats[i][head];
                end
                chk("vector_data", u_if.out_data, exp);
                chk("vector_last", u_if.out_last, (head == m_batch));
                if (stalled) chk("stall_hold", u_if.out_data, stall_data);
                if (u_if.out_ready) begin
                    got_vecs[head] = u_if.out_data;
                    if (u_if.out_last) chk("busy_fall", busy, 1'b0);
                    head++;
                    stalled = 1'b0;
                end else begin
                    stalled    = 1'b1;
                    stall_data = u_if.out_data;
                end
            end
        end else if (stalled) begin
            chk("stall_valid", u_if.out_valid, 1'b1);
            stalled = 1'b0;
        end
    end

    task automatic do_start(input int lr, input int b);
        start    = 1'b1;
        last_row = 5'(lr);
        batch    = 6'(b);
        foreach (beats[i]) beats[i].delete();
        m_lr    = lr;
        m_batch = b;
        head    = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run_batch(input int lr, input int b, input int mode, input bit rnd_data,
                             input bit gaps, input bit noise, input int stop,
                             input int restart_at, input logic [31:0] mask);
        int sent [LANES];
        int cyc;
        int target;
        lane_t v;
        target = (stop < 0) ? b + 1 : stop;
        cyc = 0;
        foreach (sent[i]) sent[i] = 0;
        while (head < target && cyc < 3000) begin
            act_valid = '0;
            act_in    = '0;
            for (int i = 0; i < LANES; i++) begin
                if (i <= lr) begin
                    if (mask[i] && sent[i] < b + 1 && cyc >= lr - i &&
                        !(gaps && $urandom_range(0, 3) == 0)) begin
                        v = rnd_data ? lane_t'($urandom) : lane_t'(sent[i] * 256 + i);
                        act_valid[i]         = 1'b1;
                        act_in[i*DW +: DW]   = v;
                        beats[i].push_back(v);
                        sent[i]++;
                    end
                end else if (noise && $urandom_range(0, 1) == 1) begin
                    act_valid[i]       = 1'b1;
                    act_in[i*DW +: DW] = lane_t'($urandom);
                end
            end
            case (mode)
                0: u_if.out_ready = 1'b1;
                1: u_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: u_if.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc == restart_at) begin
                start    = 1'b1;
                last_row = 5'd3;
                batch    = 6'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        act_valid = '0;
        start     = 1'b0;
        if (cyc >= 3000) chk("batch_timeout", head, target);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        last_row       = '0;
        batch          = '0;
        act_in         = '0;
        act_valid      = '0;
        u_if.out_ready = 1'b0;
        m_lr = 0; m_batch = 0; head = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", u_if.out_valid, 1'b0);
        chk("rst_out_last", u_if.out_last, 1'b0);
        chk("rst_out_data", u_if.out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Aligned stream with literal pins.
        do_start(31, 3);
        chk("busy_after_start", busy, 1'b1);
        run_batch(31, 3, 0, 1'b0, 1'b0, 1'b0, -1, -1, '1);
        chk("aligned_busy_idle", busy, 1'b0);
        chk("aligned_v0_l0", got_vecs[0][15:0], 16'h0000);
        chk("aligned_v2_l5", got_vecs[2][5*DW +: DW], 16'h0205);
        chk("aligned_v3_l31", got_vecs[3][31*DW +: DW], 16'h031F);

        // Partial rows with noise on inactive lanes.
        do_start(7, 0);
        run_batch(7, 0, 0, 1'b0, 1'b0, 1'b1, -1, -1, '1);
        chk("partial_upper_zero", got_vecs[0][511:128], '0);
        chk("partial_l7", got_vecs[0][7*DW +: DW], 16'h0007);

        // Backpressure.
        do_start(31, 9);
        run_batch(31, 9, 1, 1'b1, 1'b0, 1'b0, -1, -1, '1);
        chk("bp_count", head, 10);
        chk("bp_err", err, 1'b0);

        // Overflow: lane 1 fills while lane 0 is idle, so nothing drains.
        do_start(1, 63);
        u_if.out_ready = 1'b0;
        for (int k = 0; k < 65; k++) begin
            act_valid          = 32'h2;
            act_in             = '0;
            act_in[DW +: DW]   = lane_t'(k * 256 + 1);
            if (k < 64) beats[1].push_back(lane_t'(k * 256 + 1));
            @(posedge clk); #1;
            if (k == 63) chk("ovf_err_before", err, 1'b0);
        end
        act_valid = '0;
        chk("ovf_err_set", err, 1'b1);
        run_batch(1, 63, 0, 1'b0, 1'b0, 1'b0, -1, -1, 32'h1);
        chk("ovf_count", head, 64);
        chk("ovf_last_vec", got_vecs[63][31:0], 32'h3F01_3F00);
        chk("ovf_err_sticky", err, 1'b1);

        // Reset mid-batch.
        do_start(31, 4);
        run_batch(31, 4, 0, 1'b1, 1'b0, 1'b0, 2, -1, '1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", u_if.out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_start(31, 0);
        run_batch(31, 0, 0, 1'b1, 1'b0, 1'b0, -1, -1, '1);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_one_vec", head, 1);

        // Ignored start during RUN.
        do_start(31, 5);
        run_batch(31, 5, 0, 1'b1, 1'b1, 1'b0, -1, 10, '1);
        repeat (4) @(posedge clk);
        #1;
        chk("ign_count", head, 6);
        chk("ign_idle_valid", u_if.out_valid, 1'b0);
        chk("ign_idle_busy", busy, 1'b0);

        // Randomized batches.
        for (int t = 0; t < 6; t++) begin
            int lr, b;
            lr = $urandom_range(0, 31);
            b  = $urandom_range(0, 20);
            do_start(lr, b);
            run_batch(lr, b, 2, 1'b1, 1'b1, 1'b1, -1, -1, '1);
            chk("rand_busy_idle", busy, 1'b0);
            chk("rand_err", err, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
